shadow_accumulator: RTL and testbench
=====================================

SHADOW_ACCUMULATOR -- requirements
Module: shadow_accumulator

Interface
REQ-001 SHALL have parameter NUM_SHOTS, default 1024, shots per estimation run (range 1..65535).
REQ-002 SHALL have parameter ACC_W, default 24, signed sum width.
REQ-003 SHALL have parameter VAL_W, default NUM_QUBITS+2 (7), signed per-shot value width.
REQ-004 SHALL have port i_clk, input, 1, sole clock; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port i_start, input, 1, single-cycle pulse that clears and arms a run.
REQ-007 SHALL have port i_value, input, VAL_W, two's-complement per-shot estimate from measureClifford o_value.
REQ-008 SHALL have port i_valid, input, 1, single-cycle strobe from measureClifford o_ready qualifying i_value.
REQ-009 SHALL have port o_sum, output, ACC_W, signed running/final sum.
REQ-010 SHALL have port o_zero_cnt, output, 16, count of shots with i_value==0 (rejected shots).
REQ-011 SHALL have port o_shot_cnt, output, 16, shots accepted in the current run.
REQ-012 SHALL have port o_done, output, 1, level; result is final and held.
REQ-013 SHALL have port i_ack, input, 1, consumer acknowledge of o_done.
REQ-014 SHALL have port o_sat, output, 1, sticky sum-saturation flag for the run.
REQ-015 SHALL have port o_drop, output, 1, one-cycle pulse when i_valid arrives outside ACC.
REQ-016 SHALL have port o_sqsum, output, ACC_W+VAL_W, sum of squared values (see REQ-030).

Function
REQ-017 SHALL implement FSM IDLE -> ACC -> DONE -> IDLE.
REQ-018 IDLE: i_start -> ACC next cycle; clears o_sum, o_sqsum, counters, and o_sat.
REQ-019 ACC: each i_valid sign-extends i_value to ACC_W, adds it to o_sum, and increments o_shot_cnt; it also increments o_zero_cnt when i_value==0.
REQ-020 Accumulator outputs SHALL update on the edge that samples i_valid (visible 1 cycle later).
REQ-021 The i_valid that makes o_shot_cnt==NUM_SHOTS SHALL move the FSM to DONE; o_done rises in the same cycle the final sum is visible.
REQ-022 DONE: o_done=1 with all outputs frozen until i_ack; i_ack -> IDLE next cycle and o_done=0.
REQ-023 i_start in ACC or DONE SHALL abort and restart: clear, then enter ACC; a coincident i_valid is discarded and o_drop is not pulsed.
REQ-024 i_start with i_valid in IDLE: start wins, and the sample is discarded without o_drop.
REQ-025 i_valid in IDLE or DONE (without i_start) SHALL pulse o_drop and leave state unchanged.
REQ-026 Sum SHALL saturate at +(2^(ACC_W-1)-1) / -(2^(ACC_W-1)); any clamp sets o_sat until the next i_start or reset.
REQ-027 i_ack outside DONE SHALL be ignored.

Reset
REQ-028 i_rst SHALL asynchronously force IDLE with o_sum=0, o_sqsum=0, o_zero_cnt=0, o_shot_cnt=0, o_done=0, o_sat=0, o_drop=0.
REQ-029 Reset mid-run SHALL discard partial results; the first post-reset i_valid without i_start pulses o_drop.

Configuration
REQ-030 Macro SHADOW_ACC_SQSUM_EN defined: o_sqsum accumulates i_value*i_value (unsigned, non-saturating) alongside o_sum, for variance estimation.
REQ-031 Macro undefined: the squaring logic is absent and o_sqsum is tied to 0; the port still exists.

Structure
REQ-032 Package shadow_pkg SHALL hold NUM_QUBITS (5), VAL_W, the FSM state enum {IDLE, ACC, DONE}, and the counter width constant (16).
REQ-033 Sub-module sat_add (signed saturating adder, parameter ACC_W, outputs sum and overflow flag) SHALL perform the o_sum update.

Verification (bench NUM_SHOTS=4, ACC_W=8)
REQ-034 Start; values 32, -32, 16, 0 -> o_sum=16, o_zero_cnt=1, o_shot_cnt=4, o_done=1 one cycle after the 4th strobe; o_sqsum=2304 with the macro, 0 without.
REQ-035 Values 32, 32, 32, 32 -> o_sum clamps to 127 on the 4th shot and o_sat=1.
REQ-036 i_valid with value 32 in IDLE -> o_drop one cycle, o_sum stays 0; i_valid in DONE -> o_drop, outputs frozen.
REQ-037 Start, 2 shots, then i_start coincident with i_valid -> counters 0, FSM in ACC, no o_drop.
REQ-038 i_rst asserted after 3 shots -> all outputs 0 asynchronously; FSM in IDLE.
REQ-039 Hold DONE 10 cycles without i_ack -> outputs stable; i_ack -> o_done=0 next cycle.

Source files
------------

// File: rtl/shadow_pkg.sv
// shadow_pkg: shared constants and FSM state type for the shadow accumulator.
package shadow_pkg;

    localparam int NUM_QUBITS = 5;
    localparam int VAL_W      = NUM_QUBITS + 2;
    localparam int CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shadow_accumulator_sat_add.sv
// sat_add: signed adder that clamps to the most positive / most negative
// ACC_W-bit value and flags when a clamp happened.
module sat_add #(
    parameter int ACC_W = 24
) (
    input  logic signed [ACC_W-1:0] i_a,
    input  logic signed [ACC_W-1:0] i_b,
    output logic signed [ACC_W-1:0] o_sum,
    output logic                    o_ovf
);

    logic signed [ACC_W:0] full;

    // One guard bit: overflow shows up as guard bit differing from the MSB.
    always_comb begin
        full  = {i_a[ACC_W-1], i_a} + {i_b[ACC_W-1], i_b};
        o_ovf = full[ACC_W] ^ full[ACC_W-1];
        if (!o_ovf)
            o_sum = full[ACC_W-1:0];
        else if (full[ACC_W])
            o_sum = {1'b1, {(ACC_W-1){1'b0}}};
        else
            o_sum = {1'b0, {(ACC_W-1){1'b1}}};
    end

endmodule

// File: rtl/shadow_accumulator.sv
// shadow_accumulator: sums NUM_SHOTS signed per-shot estimates with
// saturation, counts zero-valued (rejected) shots and holds the result until
// acknowledged. Optional macro SHADOW_ACC_SQSUM_EN adds a sum of squares
// for variance estimation; without it o_sqsum is tied to zero.
//
//   state | meaning
//   IDLE  | waiting for i_start, previous result still readable
//   ACC   | accumulating i_valid samples of the current run
//   DONE  | run complete, outputs frozen until i_ack
module shadow_accumulator
    import shadow_pkg::*;
#(
    parameter int NUM_SHOTS = 1024,
    parameter int ACC_W     = 24,
    parameter int VAL_W     = shadow_pkg::VAL_W
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic signed [VAL_W-1:0]   i_value,
    input  logic                      i_valid,
    output logic signed [ACC_W-1:0]   o_sum,
    output logic [CNT_W-1:0]          o_zero_cnt,
    output logic [CNT_W-1:0]          o_shot_cnt,
    output logic                      o_done,
    input  logic                      i_ack,
    output logic                      o_sat,
    output logic                      o_drop,
    output logic [ACC_W+VAL_W-1:0]    o_sqsum
);

    localparam int              SQ_W      = ACC_W + VAL_W;
    localparam logic [CNT_W-1:0] LAST_SHOT = CNT_W'(NUM_SHOTS - 1);

    state_t                   state_q;
    state_t                   state_d;
    logic                     accept;
    logic                     last_shot;
    logic                     drop_d;
    logic signed [ACC_W-1:0]  val_ext;
    logic signed [ACC_W-1:0]  sum_next;
    logic                     sum_ovf;

    // A start always wins over a coincident sample; samples outside ACC are dropped.
    assign accept    = (state_q == ACC) && i_valid && !i_start;
    assign last_shot = accept && (o_shot_cnt == LAST_SHOT);
    assign drop_d    = i_valid && !i_start && (state_q != ACC);
    assign val_ext   = ACC_W'(i_value);

    sat_add #(.ACC_W(ACC_W)) u_sat_add (
        .i_a   (o_sum),
        .i_b   (val_ext),
        .o_sum (sum_next),
        .o_ovf (sum_ovf)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = ACC;
            ACC:     if (i_start) state_d = ACC;
                     else if (last_shot) state_d = DONE;
            DONE:    if (i_start) state_d = ACC;
                     else if (i_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        o_done = (state_q == DONE);
    end

    // Sum, counters, sticky saturation and the drop pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sum      <= '0;
            o_zero_cnt <= '0;
            o_shot_cnt <= '0;
            o_sat      <= 1'b0;
            o_drop     <= 1'b0;
        end else begin
            o_drop <= drop_d;
            if (i_start) begin
                o_sum      <= '0;
                o_zero_cnt <= '0;
                o_shot_cnt <= '0;
                o_sat      <= 1'b0;
            end else if (accept) begin
                o_sum      <= sum_next;
                o_shot_cnt <= o_shot_cnt + CNT_W'(1);
                if (i_value == '0)
                    o_zero_cnt <= o_zero_cnt + CNT_W'(1);
                if (sum_ovf)
                    o_sat <= 1'b1;
            end
        end
    end

`ifdef SHADOW_ACC_SQSUM_EN
    logic signed [2*VAL_W-1:0] val_wide;
    logic signed [2*VAL_W-1:0] val_sq;

    assign val_wide = (2*VAL_W)'(i_value);
    assign val_sq   = val_wide * val_wide;

    // Sum of squares wraps rather than saturates; a square is never negative.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            o_sqsum <= '0;
        else if (i_start)
            o_sqsum <= '0;
        else if (accept)
            o_sqsum <= o_sqsum + SQ_W'($unsigned(val_sq));
    end
`else
    assign o_sqsum = '0;
`endif

endmodule

// File: tb/tb_shadow_accumulator.sv
// tb_shadow_accumulator: random and directed stimulus against a run-level
// reference model; expected results are queued and checked by a monitor.
module tb_shadow_accumulator;

    localparam int NSH = 4;
    localparam int AW  = 8;
    localparam int VW  = 7;
    localparam int SQW = AW + VW;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic                 i_start;
    logic                 i_valid;
    logic                 i_ack;
    logic signed [VW-1:0] i_value;
    logic signed [AW-1:0] o_sum;
    logic [15:0]          o_zero_cnt;
    logic [15:0]          o_shot_cnt;
    logic                 o_done;
    logic                 o_sat;
    logic                 o_drop;
    logic [SQW-1:0]       o_sqsum;

    shadow_accumulator #(.NUM_SHOTS(NSH), .ACC_W(AW), .VAL_W(VW)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_value    (i_value),
        .i_valid    (i_valid),
        .o_sum      (o_sum),
        .o_zero_cnt (o_zero_cnt),
        .o_shot_cnt (o_shot_cnt),
        .o_done     (o_done),
        .i_ack      (i_ack),
        .o_sat      (o_sat),
        .o_drop     (o_drop),
        .o_sqsum    (o_sqsum)
    );

    always #5 i_clk = ~i_clk;

    int cyc_n = 0;
    always @(posedge i_clk) cyc_n <= cyc_n + 1;

    typedef struct {
        int     cyc;
        longint sum;
        int     zero;
        int     shots;
        bit     sat;
        bit     done;
        longint sq;
    } snap_t;

    snap_t  snap_q[$];
    snap_t  done_q[$];
    int     drop_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    bit     tb_end   = 0;
    bit     mon_fin  = 0;
    event   rst_probe;

    // reference model: run-level view of the accumulator
    int     m_mode;   // 0 idle, 1 accumulating, 2 result held
    longint m_sum;
    longint m_sq;
    int     m_zero;
    int     m_shots;
    bit     m_sat;

    function automatic void cmp(string nm, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc_n);
        end
    endfunction

    function automatic void model_clear();
        m_sum = 0; m_sq = 0; m_zero = 0; m_shots = 0; m_sat = 0;
    endfunction

    function automatic snap_t model_snap(int cyc);
        snap_t s;
        s.cyc = cyc; s.sum = m_sum; s.zero = m_zero; s.shots = m_shots;
        s.sat = m_sat; s.done = (m_mode == 2); s.sq = m_sq;
        return s;
    endfunction

    task automatic step(input bit st, input bit vl, input int val, input bit ak);
        bit exp_drop;
        bit exp_done;
        exp_drop = 0;
        exp_done = 0;
        i_start = st; i_valid = vl; i_value = VW'(val); i_ack = ak;
        if (st) begin
            m_mode = 1;
            model_clear();
        end else begin
            if (vl) begin
                if (m_mode == 1) begin
                    m_sum = m_sum + val;
                    if (m_sum > 127)  begin m_sum = 127;  m_sat = 1; end
                    if (m_sum < -128) begin m_sum = -128; m_sat = 1; end
                    if (val == 0) m_zero++;
                    m_shots++;
`ifdef SHADOW_ACC_SQSUM_EN
                    m_sq = (m_sq + longint'(val) * val) % (longint'(1) << SQW);
`endif
                    if (m_shots == NSH) begin
                        m_mode = 2;
                        exp_done = 1;
                    end
                end else begin
                    exp_drop = 1;
                end
            end
            if (ak && m_mode == 2 && !exp_done) m_mode = 0;
        end
        @(posedge i_clk);
        #1;
        i_start = 0; i_valid = 0; i_ack = 0;
        if (exp_drop) drop_q.push_back(cyc_n);
        if (exp_done) done_q.push_back(model_snap(cyc_n));
        snap_q.push_back(model_snap(cyc_n));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0);
    endtask

    task automatic async_reset_probe();
        i_rst = 1;
        m_mode = 0;
        model_clear();
        #1;
        snap_q.push_back(model_snap(-1));
        -> rst_probe;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 0;
    endtask

    // monitor: all comparisons happen here
    initial begin : monitor
        bit    prev_done;
        snap_t s;
        int    e;
        prev_done = 0;
        forever begin
            @(negedge i_clk or rst_probe);
            while (snap_q.size() > 0 && snap_q[0].cyc <= cyc_n) begin
                s = snap_q.pop_front();
                cmp("o_sum", o_sum, s.sum);
                cmp("o_zero_cnt", o_zero_cnt, s.zero);
                cmp("o_shot_cnt", o_shot_cnt, s.shots);
                cmp("o_sat", o_sat, s.sat);
                cmp("o_done", o_done, s.done);
                cmp("o_sqsum", o_sqsum, s.sq);
                if (s.cyc < 0) cmp("o_drop_rst", o_drop, 0);
            end
            if (!i_rst && !i_clk) begin
                if (o_drop) begin
                    if (drop_q.size() == 0) cmp("unexpected_o_drop", 1, 0);
                    else begin
                        e = drop_q.pop_front();
                        cmp("o_drop_cycle", cyc_n, e);
                    end
                end
                if (o_done && !prev_done) begin
                    if (done_q.size() == 0) cmp("unexpected_done", 1, 0);
                    else begin
                        s = done_q.pop_front();
                        cmp("done_cycle", cyc_n, s.cyc);
                        cmp("result_sum", o_sum, s.sum);
                        cmp("result_zero_cnt", o_zero_cnt, s.zero);
                        cmp("result_shot_cnt", o_shot_cnt, s.shots);
                        cmp("result_sat", o_sat, s.sat);
                        cmp("result_sqsum", o_sqsum, s.sq);
                    end
                end
            end
            prev_done = o_done;
            if (tb_end && !mon_fin) begin
                cmp("pending_drop_events", drop_q.size(), 0);
                cmp("pending_done_events", done_q.size(), 0);
                cmp("pending_snapshots", snap_q.size(), 0);
                mon_fin = 1;
            end
        end
    end

    initial begin : stimulus
        i_rst = 1; i_start = 0; i_valid = 0; i_ack = 0; i_value = '0;
        m_mode = 0;
        model_clear();
        #3;
        snap_q.push_back(model_snap(-1));
        -> rst_probe;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 0;

        // sample in IDLE is dropped
        step(0, 1, 32, 0);
        idle(2);

        // nominal run, gaps between strobes, then hold and drop in DONE
        step(1, 0, 0, 0);
        step(0, 1, 32, 0);
        idle(1);
        step(0, 1, -32, 0);
        step(0, 1, 16, 0);
        idle(2);
        step(0, 1, 0, 0);
        idle(10);
        step(0, 1, 32, 0);
        idle(2);
        step(0, 0, 0, 1);
        idle(2);
        step(0, 0, 0, 1);

        // saturation on the fourth shot
        step(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(0, 1, 32, 0);
        step(0, 0, 0, 1);

        // negative clamp, ack in ACC ignored
        step(1, 0, 0, 0);
        step(0, 1, -64, 1);
        step(0, 1, -64, 0);
        step(0, 1, -64, 0);
        step(0, 1, 63, 0);
        step(0, 0, 0, 1);

        // restart mid-run with a coincident strobe, then complete
        step(1, 0, 0, 0);
        step(0, 1, 5, 0);
        step(0, 1, 0, 0);
        step(1, 1, 9, 0);
        for (int k = 0; k < 4; k++) step(0, 1, k - 2, 0);
        step(1, 1, 7, 0);
        step(0, 1, 1, 0);

        // asynchronous reset after three shots
        step(1, 0, 0, 0);
        step(0, 1, 10, 0);
        step(0, 1, 20, 0);
        step(0, 1, 30, 0);
        @(negedge i_clk);
        #2;
        async_reset_probe();
        step(0, 1, 32, 0);
        step(1, 1, 3, 0);

        // randomized traffic
        for (int k = 0; k < 500; k++) begin
            bit st, vl, ak;
            int val;
            st  = ($urandom_range(0, 24) == 0);
            vl  = ($urandom_range(0, 2) != 0);
            ak  = ($urandom_range(0, 5) == 0);
            val = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 127)) - 64;
            step(st, vl, val, ak);
        end
        idle(3);

        tb_end = 1;
        for (int k = 0; k < 20 && !mon_fin; k++) @(posedge i_clk);
        if (!mon_fin) begin
            $display("FAIL monitor_timeout: monitor did not finish");
            $fatal(1, "monitor did not finish");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
